mac_tx_arbiter: RTL and testbench

//  Frame-granular round-robin arbiter in front of the MAC TX path (CRC append stage).

---
 rtl/mac_tx_arbiter.sv | 111 +++++++++++
 tb/tb_mac_tx_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arbiter.sv
// rtl/mac_tx_arbiter.sv - frame-granular round-robin arbiter in front of the MAC TX path
// Optional inter-frame gap state is built only when MAC_TX_ARB_IFG_EN is defined.
module mac_tx_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int IFG_CYCLES = 12,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                   logic_clk,
    input  logic                   logic_rst,
    input  logic [NUM_REQ*8-1:0]   req_tdata_in,
    input  logic [NUM_REQ-1:0]     req_tvalid_in,
    output logic [NUM_REQ-1:0]     req_tready_out,
    input  logic [NUM_REQ-1:0]     req_tlast_in,
    output logic [7:0]             mac_tdata_out,
    output logic                   mac_tvalid_out,
    input  logic                   mac_tready_in,
    output logic                   mac_tlast_out,
    output logic [ID_W-1:0]        grant_id_out,
    output logic                   busy_out
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || IFG_CYCLES < 1) begin : g_param_err
        $error("mac_tx_arbiter: NUM_REQ must be 2..8 and IFG_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_grant;

`ifdef MAC_TX_ARB_IFG_EN
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);
    logic [GAP_W-1:0]  r_gap_cnt;
`endif

    logic              w_any;
    logic [ID_W-1:0]   w_winner;
    logic              w_xfer;
    logic              w_hs_last;

    // Walk candidates from farthest to nearest so the nearest valid after r_ptr wins.
    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_any    = 1'b0;
        w_winner = r_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (req_tvalid_in[v_idx]) begin
                w_any    = 1'b1;
                w_winner = ID_W'(v_idx);
            end
        end
    end

    assign w_xfer         = (r_state == S_XFER);
    assign mac_tdata_out  = w_xfer ? req_tdata_in[{r_grant, 3'b000} +: 8] : 8'h00;
    assign mac_tvalid_out = w_xfer & req_tvalid_in[r_grant];
    assign mac_tlast_out  = w_xfer & req_tlast_in[r_grant];
    assign req_tready_out = w_xfer ? (NUM_REQ'(mac_tready_in) << r_grant) : '0;
    assign busy_out       = w_xfer;
    assign grant_id_out   = r_grant;
    assign w_hs_last      = mac_tvalid_out & mac_tready_in & mac_tlast_out;

    always_ff @(posedge logic_clk) begin
        if (!logic_rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= ID_W'(NUM_REQ - 1);
            r_grant   <= '0;
`ifdef MAC_TX_ARB_IFG_EN
            r_gap_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_winner;
                        r_ptr   <= w_winner;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_hs_last) begin
`ifdef MAC_TX_ARB_IFG_EN
                        r_state   <= S_GAP;
                        r_gap_cnt <= GAP_W'(IFG_CYCLES - 1);
`else
                        r_state   <= S_IDLE;
`endif
                    end
                end
`ifdef MAC_TX_ARB_IFG_EN
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb/tb_mac_tx_arbiter.sv - randomized self-checking bench for mac_tx_arbiter
module tb_mac_tx_arbiter;

    localparam int NR  = 3;
    localparam int IFG = 12;
`ifdef MAC_TX_ARB_IFG_EN
    localparam int GAPC = IFG;
`else
    localparam int GAPC = 0;
`endif

    logic            logic_clk = 1'b0;
    logic            logic_rst;
    logic [NR*8-1:0] req_tdata_in;
    logic [NR-1:0]   req_tvalid_in;
    logic [NR-1:0]   req_tready_out;
    logic [NR-1:0]   req_tlast_in;
    logic [7:0]      mac_tdata_out;
    logic            mac_tvalid_out;
    logic            mac_tready_in;
    logic            mac_tlast_out;
    logic [1:0]      grant_id_out;
    logic            busy_out;

    mac_tx_arbiter #(.NUM_REQ(NR), .IFG_CYCLES(IFG)) dut (
        .logic_clk      (logic_clk),
        .logic_rst      (logic_rst),
        .req_tdata_in   (req_tdata_in),
        .req_tvalid_in  (req_tvalid_in),
        .req_tready_out (req_tready_out),
        .req_tlast_in   (req_tlast_in),
        .mac_tdata_out  (mac_tdata_out),
        .mac_tvalid_out (mac_tvalid_out),
        .mac_tready_in  (mac_tready_in),
        .mac_tlast_out  (mac_tlast_out),
        .grant_id_out   (grant_id_out),
        .busy_out       (busy_out)
    );

    always #5 logic_clk = ~logic_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each source holds a queue of pending beats; a frame ends where q_last is 1.
    logic [7:0] q_data [NR][$];
    logic       q_last [NR][$];

    task automatic add_frame(input int src);
        int len;
        len = $urandom_range(6, 1);
        for (int b = 0; b < len; b++) begin
            q_data[src].push_back(8'($urandom));
            q_last[src].push_back(b == len - 1);
        end
    endtask

    // Link model: who owns the link (-1 = nobody), round-robin history and gap countdown.
    int owner, rr_last, exp_grant, gap, hs_src, frames;
    int vprob, rprob;
    bit rst_now;
    bit found;
    int c;

    initial begin
        logic_rst     = 1'b0;
        req_tdata_in  = '0;
        req_tvalid_in = '0;
        req_tlast_in  = '0;
        mac_tready_in = 1'b0;
        frames        = 0;
        repeat (3) @(posedge logic_clk);
        @(negedge logic_clk);
        chk("rst_tvalid", 32'(mac_tvalid_out), 0);
        chk("rst_tlast",  32'(mac_tlast_out), 0);
        chk("rst_tdata",  32'(mac_tdata_out), 0);
        chk("rst_tready", 32'(req_tready_out), 0);
        chk("rst_busy",   32'(busy_out), 0);
        chk("rst_grant",  32'(grant_id_out), 0);

        owner = -1; rr_last = NR - 1; exp_grant = 0; gap = 0;
        @(posedge logic_clk);
        #1;
        logic_rst = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc < 1000) begin
                vprob = 60; rprob = 70;
            end else if (cyc < 2000) begin
                vprob = 100; rprob = 100;
            end else begin
                vprob = 85; rprob = 50;
            end
            rst_now = (cyc == 1500) || (cyc == 2500);

            for (int i = 0; i < NR; i++) begin
                if (q_data[i].size() == 0) add_frame(i);
                if ($urandom_range(99, 0) < vprob) begin
                    req_tvalid_in[i]        = 1'b1;
                    req_tdata_in[i*8 +: 8]  = q_data[i][0];
                    req_tlast_in[i]         = q_last[i][0];
                end else begin
                    req_tvalid_in[i]        = 1'b0;
                    req_tdata_in[i*8 +: 8]  = 8'($urandom);
                    req_tlast_in[i]         = 1'($urandom);
                end
            end
            mac_tready_in = ($urandom_range(99, 0) < rprob);
            logic_rst     = rst_now ? 1'b0 : 1'b1;

            @(negedge logic_clk);
            hs_src = -1;
            if (!rst_now) begin
                if (owner >= 0) begin
                    chk("xfer_tvalid", 32'(mac_tvalid_out), 32'(req_tvalid_in[owner]));
                    if (req_tvalid_in[owner]) begin
                        chk("xfer_tdata", 32'(mac_tdata_out), 32'(q_data[owner][0]));
                        chk("xfer_tlast", 32'(mac_tlast_out), 32'(q_last[owner][0]));
                    end
                    chk("xfer_tready", 32'(req_tready_out), 32'(32'(mac_tready_in) << owner));
                    chk("xfer_busy",   32'(busy_out), 1);
                    chk("xfer_grant",  32'(grant_id_out), 32'(owner));
                    if (req_tvalid_in[owner] && mac_tready_in) hs_src = owner;
                end else begin
                    chk("idle_tvalid", 32'(mac_tvalid_out), 0);
                    chk("idle_tlast",  32'(mac_tlast_out), 0);
                    chk("idle_tdata",  32'(mac_tdata_out), 0);
                    chk("idle_tready", 32'(req_tready_out), 0);
                    chk("idle_busy",   32'(busy_out), 0);
                    chk("idle_grant",  32'(grant_id_out), 32'(exp_grant));
                end

                if (owner >= 0) begin
                    if (hs_src >= 0 && q_last[owner][0]) begin
                        owner = -1;
                        gap   = GAPC;
                        frames++;
                    end
                end else if (gap > 0) begin
                    gap--;
                end else begin
                    found = 1'b0;
                    for (int k = 1; k <= NR; k++) begin
                        c = (rr_last + k) % NR;
                        if (!found && req_tvalid_in[c]) begin
                            found     = 1'b1;
                            owner     = c;
                            rr_last   = c;
                            exp_grant = c;
                        end
                    end
                end
            end else begin
                owner = -1; rr_last = NR - 1; exp_grant = 0; gap = 0;
                for (int i = 0; i < NR; i++) begin
                    q_data[i].delete();
                    q_last[i].delete();
                end
            end

            @(posedge logic_clk);
            #1;
            if (hs_src >= 0) begin
                void'(q_data[hs_src].pop_front());
                void'(q_last[hs_src].pop_front());
            end
        end

        chk("traffic", 32'(frames > 100), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
